gate_bit_packer: RTL and testbench

- Downstream consumer of the gated single-bit pipeline output, which has no backpressure.
- Packs the valid-qualified bit stream LSB-first into WIDTH-bit words.
- Queues completed words in a small FIFO for a valid/ready consumer.
- Supports explicit flush of a partial word and records dropped words in a sticky overflow flag.

---
 rtl/gate_bit_packer.sv | 251 +++++++++++++++++++++++++
 tb/tb_gate_bit_packer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gate_bit_packer.sv
// gate_bit_packer: collects a valid-qualified single-bit stream LSB-first into
// WIDTH-bit words and queues finished words (with their bit count) in a small
// FIFO for a valid/ready consumer. A partial word can be flushed early. A word
// that arrives while the queue is full and not draining is dropped, and the
// sticky overflow flag records the loss.

module gate_bit_packer #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       input_valid,
   input  logic                       in_bit,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_word,
   output logic [$clog2(WIDTH+1)-1:0] out_count,
   output logic                       overflow
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = $clog2(FIFO_DEPTH + 1);

   localparam logic [IW-1:0]    IDX_ZERO  = {IW{1'b0}};
   localparam logic [IW-1:0]    IDX_ONE   = IW'(1);
   localparam logic [IW-1:0]    IDX_LAST  = IW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]    CNT_FULL  = CW'(WIDTH);
   localparam logic [PW-1:0]    PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
   localparam logic [OW-1:0]    OCC_ZERO  = {OW{1'b0}};
   localparam logic [OW-1:0]    OCC_ONE   = OW'(1);
   localparam logic [OW-1:0]    OCC_FULL  = OW'(FIFO_DEPTH);
   localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

   // Accumulator state
   logic [WIDTH-1:0] acc_r;
   logic [IW-1:0]    idx_r;

   // Queue state
   logic [WIDTH-1:0] mem_word_r  [FIFO_DEPTH];
   logic [CW-1:0]    mem_count_r [FIFO_DEPTH];
   logic [PW-1:0]    rd_r;
   logic [PW-1:0]    wr_r;
   logic [OW-1:0]    occ_r;

   // Registered outputs
   logic             out_valid_r;
   logic [WIDTH-1:0] out_word_r;
   logic [CW-1:0]    out_count_r;
   logic             overflow_r;

   // Combinational next-state helpers
   logic [WIDTH-1:0] acc_with_bit_s;
   logic [CW-1:0]    fill_count_s;
   logic             complete_s;
   logic             push_req_s;
   logic [CW-1:0]    push_count_s;
   logic             pop_s;
   logic             full_s;
   logic             push_ok_s;
   logic             drop_s;
   logic [OW-1:0]    occ_next_s;
   logic [PW-1:0]    rd_next_s;
   logic [WIDTH-1:0] head_word_s;
   logic [CW-1:0]    head_count_s;

   // Fold the incoming bit into the accumulator image and work out whether a
   // word leaves this cycle (completion or flush of a non-empty partial word).
   always_comb begin
      acc_with_bit_s = acc_r;
      if (input_valid) begin
         acc_with_bit_s[idx_r] = in_bit;
      end else begin
         acc_with_bit_s = acc_r;
      end
      fill_count_s = CW'(idx_r) + CW'(input_valid);
      complete_s   = input_valid && (idx_r == IDX_LAST);
      push_req_s   = complete_s || (flush && (fill_count_s != CNT_ZERO));
      if (complete_s) begin
         push_count_s = CNT_FULL;
      end else begin
         push_count_s = fill_count_s;
      end
   end

   // Queue handshake: a full queue still takes a word when the head pops in
   // the same cycle; otherwise the new word is dropped.
   always_comb begin
      pop_s     = (occ_r != OCC_ZERO) && out_ready;
      full_s    = (occ_r == OCC_FULL);
      push_ok_s = push_req_s && (!full_s || pop_s);
      drop_s    = push_req_s && full_s && !pop_s;
      if (pop_s) begin
         rd_next_s = rd_r + PTR_ONE;
      end else begin
         rd_next_s = rd_r;
      end
   end

   // Next occupancy from the push/pop pair.
   always_comb begin
      occ_next_s = occ_r;
      case ({push_ok_s, pop_s})
         2'b10:   occ_next_s = occ_r + OCC_ONE;
         2'b01:   occ_next_s = occ_r - OCC_ONE;
         default: occ_next_s = occ_r;
      endcase
   end

   // Next head entry; the word being written this cycle becomes head when it
   // lands in the slot the read pointer moves to.
   always_comb begin
      head_word_s  = WORD_ZERO;
      head_count_s = CNT_ZERO;
      if (occ_next_s == OCC_ZERO) begin
         head_word_s  = WORD_ZERO;
         head_count_s = CNT_ZERO;
      end else if (push_ok_s && (wr_r == rd_next_s)) begin
         head_word_s  = acc_with_bit_s;
         head_count_s = push_count_s;
      end else begin
         head_word_s  = mem_word_r[rd_next_s];
         head_count_s = mem_count_r[rd_next_s];
      end
   end

   // Accumulator: collect bits, clear after every emitted or dropped word.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= WORD_ZERO;
         idx_r <= IDX_ZERO;
      end else if (push_req_s) begin
         acc_r <= WORD_ZERO;
         idx_r <= IDX_ZERO;
      end else if (input_valid) begin
         acc_r <= acc_with_bit_s;
         idx_r <= idx_r + IDX_ONE;
      end else begin
         acc_r <= acc_r;
         idx_r <= idx_r;
      end
   end

   // Queue storage: write the accepted word at the write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_word_r[i]  <= WORD_ZERO;
            mem_count_r[i] <= CNT_ZERO;
         end
      end else if (push_ok_s) begin
         mem_word_r[wr_r]  <= acc_with_bit_s;
         mem_count_r[wr_r] <= push_count_s;
      end else begin
         mem_word_r  <= mem_word_r;
         mem_count_r <= mem_count_r;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_r  <= PTR_ZERO;
         wr_r  <= PTR_ZERO;
         occ_r <= OCC_ZERO;
      end else begin
         rd_r  <= rd_next_s;
         occ_r <= occ_next_s;
         if (push_ok_s) begin
            wr_r <= wr_r + PTR_ONE;
         end else begin
            wr_r <= wr_r;
         end
      end
   end

   // Registered head view and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_word_r  <= WORD_ZERO;
         out_count_r <= CNT_ZERO;
         overflow_r  <= 1'b0;
      end else begin
         out_valid_r <= (occ_next_s != OCC_ZERO);
         out_word_r  <= head_word_s;
         out_count_r <= head_count_s;
         overflow_r  <= overflow_r | drop_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_word  = out_word_r;
   assign out_count = out_count_r;
   assign overflow  = overflow_r;

`ifdef ASSERT_ON
   gate_bit_packer_chk #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .occ       (occ_r),
      .out_valid (out_valid_r),
      .out_word  (out_word_r),
      .out_count (out_count_r)
   );
`endif

endmodule

`ifdef ASSERT_ON
// Invariant checker for gate_bit_packer.
module gate_bit_packer_chk #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 2
) (
   input logic                       clk,
   input logic                       rst,
   input logic [$clog2(FIFO_DEPTH+1)-1:0] occ,
   input logic                       out_valid,
   input logic [WIDTH-1:0]           out_word,
   input logic [$clog2(WIDTH+1)-1:0] out_count
);

   localparam int CW = $clog2(WIDTH + 1);

   function automatic logic [WIDTH-1:0] unused_mask(input logic [CW-1:0] cnt);
      logic [WIDTH-1:0] m;
      m = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (i >= int'(cnt));
      end
      return m;
   endfunction

   a_occ_bound : assert property (@(posedge clk) disable iff (rst)
      int'(occ) <= FIFO_DEPTH);
   a_count_nonzero : assert property (@(posedge clk) disable iff (rst)
      out_valid |-> (out_count != {CW{1'b0}}));
   a_unused_bits_zero : assert property (@(posedge clk) disable iff (rst)
      out_valid |-> ((out_word & unused_mask(out_count)) == {WIDTH{1'b0}}));

endmodule
`endif

// File: tb/tb_gate_bit_packer.sv
// Directed table-driven bench for gate_bit_packer (WIDTH=8, FIFO_DEPTH=2).
// Each record drives one clock cycle and states the outputs expected after it.

module tb_gate_bit_packer;

   logic       clk;
   logic       rst;
   logic       input_valid;
   logic       in_bit;
   logic       flush;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_word;
   logic [3:0] out_count;
   logic       overflow;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       r;
      logic       iv;
      logic       b;
      logic       fl;
      logic       rdy;
      logic       ev;
      logic [7:0] ew;
      logic [3:0] ec;
      logic       eo;
   } vec_t;

   vec_t vecs[$];

   gate_bit_packer #(.WIDTH(8), .FIFO_DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .input_valid (input_valid),
      .in_bit      (in_bit),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_word    (out_word),
      .out_count   (out_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void add(logic r, logic iv, logic b, logic fl, logic rdy,
                               logic ev, logic [7:0] ew, logic [3:0] ec, logic eo);
      vec_t v;
      v.r = r; v.iv = iv; v.b = b; v.fl = fl; v.rdy = rdy;
      v.ev = ev; v.ew = ew; v.ec = ec; v.eo = eo;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
      end
   endtask

   task automatic check_all(int idx, logic ev, logic [7:0] ew, logic [3:0] ec, logic eo);
      check("out_valid", idx, 32'(out_valid), 32'(ev));
      check("out_word",  idx, 32'(out_word),  32'(ew));
      check("out_count", idx, 32'(out_count), 32'(ec));
      check("overflow",  idx, 32'(overflow),  32'(eo));
   endtask

   task automatic drive(logic r, logic iv, logic b, logic fl, logic rdy);
      rst = r; input_valid = iv; in_bit = b; flush = fl; out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pat;

      rst = 1'b1; input_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;

      // Reset state
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);

      // Full word back-to-back: 1,0,1,1,0,0,1,0 -> 0x4D
      pat = 8'h4D;
      for (int i = 0; i < 8; i++)
         add(1'b0, 1'b1, pat[i], 1'b0, 1'b1, (i == 7), (i == 7) ? 8'h4D : 8'h00,
             (i == 7) ? 4'd8 : 4'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

      // Same word with 3 idle cycles after bits 2 and 5
      for (int i = 0; i < 8; i++) begin
         add(1'b0, 1'b1, pat[i], 1'b0, 1'b1, (i == 7), (i == 7) ? 8'h4D : 8'h00,
             (i == 7) ? 4'd8 : 4'd0, 1'b0);
         if (i == 1 || i == 4)
            for (int k = 0; k < 3; k++)
               add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      end
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

      // Flush alone after 1,1,0 -> 0x03 count 3
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 4'd3, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      // 1,1 then bit 1 together with flush -> 0x07 count 3
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h07, 4'd3, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      // Flush with nothing pending emits nothing
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

      // Stalled consumer, 24 ones: two words queued, third dropped
      for (int i = 0; i < 24; i++)
         add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i >= 7), (i >= 7) ? 8'hFF : 8'h00,
             (i >= 7) ? 4'd8 : 4'd0, (i == 23));
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd8, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);

      // Full queue, pop in the same cycle as a completing bit: word accepted
      for (int i = 0; i < 16; i++)
         add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i >= 7), (i >= 7) ? 8'hFF : 8'h00,
             (i >= 7) ? 4'd8 : 4'd0, 1'b0);
      pat = 8'h5A;
      for (int i = 0; i < 8; i++)
         add(1'b0, 1'b1, pat[i], 1'b0, (i == 7), 1'b1, 8'hFF, 4'd8, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 4'd8, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

      // Reset mid-word (with all inputs active) discards the partial word
      for (int i = 0; i < 5; i++)
         add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);
      pat = 8'hAA;
      for (int i = 0; i < 8; i++)
         add(1'b0, 1'b1, pat[i], 1'b0, 1'b1, (i == 7), (i == 7) ? 8'hAA : 8'h00,
             (i == 7) ? 4'd8 : 4'd0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

      // Apply the table
      for (int n = 0; n < vecs.size(); n++) begin
         drive(vecs[n].r, vecs[n].iv, vecs[n].b, vecs[n].fl, vecs[n].rdy);
         check_all(n, vecs[n].ev, vecs[n].ew, vecs[n].ec, vecs[n].eo);
      end

      // Hand sequence: flush on the 8th bit yields exactly one full word,
      // and a held flush afterwards emits nothing.
      pat = 8'h3C;
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, pat[i], 1'b0, 1'b1);
         check("no_early_word", 1000 + i, 32'(out_valid), 32'h0);
      end
      drive(1'b0, 1'b1, pat[7], 1'b1, 1'b1);
      check_all(2000, 1'b1, 8'h3C, 4'd8, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all(2001, 1'b0, 8'h00, 4'd0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_all(2002, 1'b0, 8'h00, 4'd0, 1'b0);

      // Hand sequence: head holds stable while the consumer stalls.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_all(3000, 1'b1, 8'h01, 4'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check_all(3001 + i, 1'b1, 8'h01, 4'd2, 1'b0);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_all(3004, 1'b0, 8'h00, 4'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
